// File: rtl/vocab_matcher_pkg.sv
// Shared types and constants for the vocabulary word matcher.
package vocab_matcher_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    CMP_MATCH = 3'd2,
    CMP_SKIP  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [63:0] NULL_CHAR = '0;

endpackage

// File: rtl/vocab_matcher.sv
// Searches a packed, null-terminated vocabulary in external sync-read SRAM for a
// query word; reports found, ordinal index and start address of the match.
module vocab_matcher
  import vocab_matcher_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int MAX_WORD_LEN = 16,
  parameter int LEN_WIDTH    = 5,
  parameter int IDX_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
  input  logic [LEN_WIDTH-1:0]               word_len,
  input  logic [ADDR_WIDTH-1:0]              vocab_base,
  input  logic [ADDR_WIDTH-1:0]              vocab_limit,
  output logic [ADDR_WIDTH-1:0]              vocab_addr,
  output logic                               vocab_rd,
  input  logic [DATA_WIDTH-1:0]              vocab_rdata,
  output logic                               busy,
  output logic                               done,
  output logic                               found,
  output logic [IDX_WIDTH-1:0]               match_idx,
  output logic [ADDR_WIDTH-1:0]              match_addr
);

  localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NULL_CHAR);

  state_t state, state_n;

  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word_q;
  logic [LEN_WIDTH-1:0]               len_q;
  logic [ADDR_WIDTH-1:0]              limit_q;
  logic [ADDR_WIDTH-1:0]              ptr;
  logic [ADDR_WIDTH-1:0]              wstart;
  logic [LEN_WIDTH-1:0]               pos;
  logic [IDX_WIDTH-1:0]               idx;
  logic                               skip_q;

  logic [DATA_WIDTH-1:0] cur_char;
  logic len_bad, is_nul, at_end, idx_sat;
  logic accept, go, pos_inc, skip_set, next_word, hit;

  // Query character at the current compare position.
  always_comb begin
    cur_char = '0;
    for (int i = 0; i < MAX_WORD_LEN; i++) begin
      if (pos == LEN_WIDTH'(i)) cur_char = word_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign len_bad = (word_len == '0) || (word_len > LEN_WIDTH'(MAX_WORD_LEN));
  assign is_nul  = (vocab_rdata == NUL);
  assign at_end  = (ptr == limit_q) || (&ptr);
  assign idx_sat = &idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    go        = 1'b0;
    pos_inc   = 1'b0;
    skip_set  = 1'b0;
    next_word = 1'b0;
    hit       = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accept  = 1'b1;
            state_n = len_bad ? DONE : ISSUE;
          end
        end
        ISSUE: state_n = skip_q ? CMP_SKIP : CMP_MATCH;
        CMP_MATCH: begin
          if (pos == '0 && is_nul) begin
            state_n = DONE;
          end else if (pos < len_q && vocab_rdata == cur_char) begin
            pos_inc = 1'b1;
            go      = 1'b1;
          end else if (pos == len_q && is_nul) begin
            // A match at the saturated index cannot be reported faithfully.
            hit     = !idx_sat;
            state_n = DONE;
          end else if (is_nul) begin
            next_word = 1'b1;
            go        = 1'b1;
          end else begin
            skip_set = 1'b1;
            go       = 1'b1;
          end
        end
        CMP_SKIP: begin
          next_word = is_nul;
          go        = 1'b1;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
      if (go) state_n = at_end ? DONE : ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      len_q      <= '0;
      limit_q    <= '0;
      ptr        <= '0;
      wstart     <= '0;
      pos        <= '0;
      idx        <= '0;
      skip_q     <= 1'b0;
      found      <= 1'b0;
      match_idx  <= '0;
      match_addr <= '0;
    end else begin
      if (accept) begin
        word_q     <= word;
        len_q      <= word_len;
        limit_q    <= vocab_limit;
        ptr        <= vocab_base;
        wstart     <= vocab_base;
        pos        <= '0;
        idx        <= '0;
        skip_q     <= 1'b0;
        found      <= 1'b0;
        match_idx  <= '0;
        match_addr <= '0;
      end
      if (hit) begin
        found      <= 1'b1;
        match_idx  <= idx;
        match_addr <= wstart;
      end
      if (go && !at_end) ptr <= ptr + 1'b1;
      if (pos_inc)  pos <= pos + 1'b1;
      if (skip_set) skip_q <= 1'b1;
      if (next_word) begin
        wstart <= ptr + 1'b1;
        pos    <= '0;
        skip_q <= 1'b0;
        if (!idx_sat) idx <= idx + 1'b1;
      end
    end
  end

  assign vocab_rd   = (state == ISSUE);
  assign vocab_addr = ptr;
  assign busy       = (state == ISSUE) || (state == CMP_MATCH) || (state == CMP_SKIP);
  assign done       = (state == DONE);

endmodule

// File: doc/vocab_matcher.md
Name: vocab_matcher

Overview:
Parametrised successor to the single-word matcher. On a start/busy/done handshake it searches a vocabulary memory for a caller-supplied word. The vocabulary holds null-terminated words packed back-to-back; an empty word (a null at a word start) ends the list. The block returns found, the word's ordinal index and its start address. It sits between the tokenizer front-end and the embedding lookup, and reads the vocabulary through an external synchronous-read SRAM port.

Parameters:
DATA_WIDTH, 8, width of one character and of one vocabulary memory word
ADDR_WIDTH, 8, vocabulary address width
MAX_WORD_LEN, 16, maximum characters in the query word
LEN_WIDTH, 5, width of word_len; must hold MAX_WORD_LEN
IDX_WIDTH, 8, width of match_idx

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only when busy=0
abort  in  1  synchronous cancel; return to IDLE, no done
word  in  MAX_WORD_LEN*DATA_WIDTH  query; char i at bits [i*DATA_WIDTH +: DATA_WIDTH]
word_len  in  LEN_WIDTH  query length in characters
vocab_base  in  ADDR_WIDTH  first vocabulary address
vocab_limit  in  ADDR_WIDTH  last readable address, inclusive
vocab_addr  out  ADDR_WIDTH  memory read address
vocab_rd  out  1  read strobe
vocab_rdata  in  DATA_WIDTH  read data, valid the cycle after vocab_rd
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse when the result is valid
found  out  1  match result
match_idx  out  IDX_WIDTH  ordinal of the matched word (first word = 0)
match_addr  out  ADDR_WIDTH  start address of the matched word

Behaviour:
- Reset: state IDLE. All outputs are 0, including vocab_addr, vocab_rd, busy, done, found, match_idx and match_addr.
- Start acceptance:
  - start is sampled in IDLE; word, word_len, vocab_base and vocab_limit are latched.
  - start while busy=1 is ignored.
  - found, match_idx and match_addr clear on acceptance.
- Invalid length: word_len=0 or word_len>MAX_WORD_LEN -> DONE next cycle with found=0.
- FSM states: IDLE, ISSUE, CMP_MATCH, CMP_SKIP, DONE. Each vocabulary byte costs exactly 2 cycles:
  - ISSUE: drive vocab_addr=ptr and vocab_rd=1.
  - CMP_*: evaluate vocab_rdata.
- ISSUE is entered with addr=vocab_base, char position pos=0, word index idx=0, word start wstart=vocab_base.
- CMP_MATCH rules, in priority order:
  - pos=0 and rdata=0 -> end of list -> DONE, found=0.
  - pos<word_len and rdata==word[pos] -> pos+1.
  - pos==word_len and rdata=0 -> DONE, found=1, match_idx=idx, match_addr=wstart.
  - Otherwise mismatch. This includes a query that is a prefix of the vocab word, and a vocab word that is a prefix of the query.
  - On mismatch: if rdata=0 the word has already ended -> next word directly; else -> CMP_SKIP path.
- CMP_SKIP: rdata=0 -> next word. Otherwise keep reading.
- Next word: wstart=ptr+1, idx+1, pos=0.
- Address advance: ptr+1, then ISSUE. If ptr==vocab_limit, or ptr+1 wraps to 0, stop instead -> DONE, found=0.
- idx saturation: idx saturates at all-ones. If a match would land at the saturated idx -> DONE, found=0.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE. found, match_idx and match_addr hold until the next accepted start.
- Latency: start sampled at cycle T with N bytes read -> done=1 at T+1+2N.
- abort: wins over all transitions; vocab_rd=0 and state IDLE next cycle; result outputs keep their cleared values.
- Reset asserted mid-search: immediate return to reset values.

Decomposition:
- Package vocab_matcher_pkg holds:
  - the state enum typedef (IDLE, ISSUE, CMP_MATCH, CMP_SKIP, DONE);
  - the constant NULL_CHAR = '0.
- Sub-module sram_rd_model, a bench-only synchronous ROM with 1-cycle latency and an INIT_FILE parameter, serves as the vocabulary.
- The RTL itself is a single module; no RTL sub-module is needed.

Test Plan:
- Vocab "cat\0dog\0\0" at base 0, limit 255; query "dog" len 3 -> found=1, match_idx=1, match_addr=4, done at T+17.
- Same vocab; query "ca" len 2 (prefix case) -> found=0, done at T+19 (9 reads, stops on null at addr 8).
- Same vocab, vocab_limit=5; query "dog" -> found=0, done at T+13, no read above addr 5.
- word_len=0 -> done at T+1, found=0, vocab_rd never asserted.
- Start pulsed again while busy -> ignored, result unchanged; abort mid-search -> no done pulse, busy=0 next cycle, new start then completes normally.
- rst_n pulsed low during CMP_SKIP -> all outputs 0 immediately; search for "cat" afterward -> found=1, match_idx=0, match_addr=0.
